// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet instruction sequencer:
// instruction bit positions, the idle word and the sequencer states.
package corelet_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 16;

    localparam int B_MODE  = 34;
    localparam int B_ACC   = 33;
    localparam int B_CEN_P = 32;
    localparam int B_WEN_P = 31;
    localparam int B_AP    = 20;
    localparam int B_CEN_X = 19;
    localparam int B_WEN_X = 18;
    localparam int B_AX    = 7;
    localparam int B_ORD   = 6;
    localparam int B_L0RD  = 3;
    localparam int B_L0WR  = 2;
    localparam int B_EXEC  = 1;
    localparam int B_LOAD  = 0;

    // Both memories deselected and in read mode; every strobe low.
    localparam logic [INST_W-1:0] IDLE_WORD =
        (35'd1 << B_CEN_P) | (35'd1 << B_WEN_P) |
        (35'd1 << B_CEN_X) | (35'd1 << B_WEN_X);

    typedef enum logic [3:0] {
        IDLE,
        W_FILL,
        W_LOAD,
        W_GAP,
        A_FILL,
        A_EXEC,
        O_DRAIN,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/seq_counter.sv
// Up-counter with restart and terminal-count flag.
// clr restarts from zero and en still adds one in the same cycle.
import corelet_pkg::*;

module seq_counter #(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= (clr ? '0 : count) + W'(en);
        end
    end

    assign last = (count == limit);

endmodule

// File: rtl/corelet_sequencer.sv
// Issues the per-cycle 35-bit instruction stream for one full
// weight-stationary convolution pass, then SFP accumulation.
import corelet_pkg::*;

module corelet_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int len_kij  = 9,
    parameter int wbase    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam int AMAX = 1 << ADDR_W;

    if (wbase + len_kij * col > AMAX || len_kij * len_nij > AMAX ||
        len_nij + 1 > AMAX || len_onij > len_nij) begin : g_addr_chk
        $error("corelet_sequencer: addresses exceed 11 bits");
    end

    state_t             state, nstate;
    logic               mode_q, mode_n;
    logic [CNT_W-1:0]   ph, kk, oo;
    logic [CNT_W-1:0]   nph, nkk, noo, ph_lim;
    logic               ph_clr, ph_en, ph_last;
    logic               k_clr, k_en, k_last;
    logic               o_clr, o_en, o_last;
    logic               rd_n, wr_n, cur_wr;
    logic [INST_W-1:0]  word;

    seq_counter #(.W(CNT_W)) u_phase (
        .clk(clk), .reset(reset), .clr(ph_clr), .en(ph_en),
        .limit(ph_lim), .count(ph), .last(ph_last)
    );

    seq_counter #(.W(CNT_W)) u_kij (
        .clk(clk), .reset(reset), .clr(k_clr), .en(k_en),
        .limit(CNT_W'(len_kij - 1)), .count(kk), .last(k_last)
    );

    seq_counter #(.W(CNT_W)) u_onij (
        .clk(clk), .reset(reset), .clr(o_clr), .en(o_en),
        .limit(CNT_W'(len_onij - 1)), .count(oo), .last(o_last)
    );

    always_comb begin
        unique case (state)
            W_FILL:  ph_lim = CNT_W'(col);
            W_LOAD:  ph_lim = CNT_W'(col - 1);
            W_GAP:   ph_lim = CNT_W'(row + col - 1);
            A_FILL:  ph_lim = CNT_W'(len_nij);
            A_EXEC:  ph_lim = CNT_W'(len_nij - 1);
            O_DRAIN: ph_lim = CNT_W'(len_nij);
            ACC:     ph_lim = CNT_W'(len_kij);
            default: ph_lim = '0;
        endcase
    end

    // In O_DRAIN the phase counter holds pops issued so far, including
    // the word currently on inst; a write always trails its pop by one.
    always_comb begin
        nstate = state;
        ph_clr = 1'b0;
        ph_en  = 1'b0;
        k_clr  = 1'b0;
        k_en   = 1'b0;
        o_clr  = 1'b0;
        o_en   = 1'b0;
        rd_n   = 1'b0;
        wr_n   = 1'b0;
        cur_wr = !inst[B_CEN_P] && !inst[B_WEN_P];
        unique case (state)
            IDLE: begin
                if (start) begin
                    nstate = W_FILL;
                    ph_clr = 1'b1;
                    k_clr  = 1'b1;
                    o_clr  = 1'b1;
                end
            end
            W_FILL: begin
                if (ph_last) begin
                    nstate = W_LOAD;
                    ph_clr = 1'b1;
                end else ph_en = 1'b1;
            end
            W_LOAD: begin
                if (ph_last) begin
                    nstate = W_GAP;
                    ph_clr = 1'b1;
                end else ph_en = 1'b1;
            end
            W_GAP: begin
                if (ph_last) begin
                    nstate = A_FILL;
                    ph_clr = 1'b1;
                end else ph_en = 1'b1;
            end
            A_FILL: begin
                if (ph_last) begin
                    nstate = A_EXEC;
                    ph_clr = 1'b1;
                end else ph_en = 1'b1;
            end
            A_EXEC: begin
                if (ph_last) begin
                    nstate = O_DRAIN;
                    ph_clr = 1'b1;
                    rd_n   = ofifo_valid;
                    ph_en  = ofifo_valid;
                end else ph_en = 1'b1;
            end
            O_DRAIN: begin
                wr_n = inst[B_ORD];
                if (cur_wr && !inst[B_ORD] && ph_last) begin
                    ph_clr = 1'b1;
                    if (k_last) begin
                        nstate = ACC;
                        k_clr  = 1'b1;
                        o_clr  = 1'b1;
                    end else begin
                        nstate = W_FILL;
                        k_en   = 1'b1;
                    end
                end else begin
                    rd_n  = ofifo_valid && (ph < CNT_W'(len_nij));
                    ph_en = rd_n;
                end
            end
            ACC: begin
                if (ph_last) begin
                    ph_clr = 1'b1;
                    if (o_last) nstate = DONE;
                    else o_en = 1'b1;
                end else ph_en = 1'b1;
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        nph    = (ph_clr ? '0 : ph) + CNT_W'(ph_en);
        nkk    = (k_clr ? '0 : kk) + CNT_W'(k_en);
        noo    = (o_clr ? '0 : oo) + CNT_W'(o_en);
        mode_n = (state == IDLE) ? mode : mode_q;
        word   = IDLE_WORD;
        unique case (nstate)
            W_FILL: begin
                if (int'(nph) < col) begin
                    word[B_CEN_X] = 1'b0;
                    word[B_AX +: ADDR_W] =
                        ADDR_W'(wbase + int'(nkk) * col + int'(nph));
                end
                word[B_L0WR] = (nph != '0);
            end
            A_FILL: begin
                if (int'(nph) < len_nij) begin
                    word[B_CEN_X] = 1'b0;
                    word[B_AX +: ADDR_W] = ADDR_W'(nph);
                end
                word[B_L0WR] = (nph != '0);
            end
            W_LOAD: begin
                word[B_L0RD] = 1'b1;
                word[B_LOAD] = 1'b1;
            end
            A_EXEC: begin
                word[B_L0RD] = 1'b1;
                word[B_EXEC] = 1'b1;
            end
            O_DRAIN: begin
                word[B_ORD] = rd_n;
                if (wr_n) begin
                    word[B_CEN_P] = 1'b0;
                    word[B_WEN_P] = 1'b0;
                    word[B_AP +: ADDR_W] =
                        ADDR_W'(int'(nkk) * len_nij + int'(ph) - 1);
                end
            end
            ACC: begin
                if (int'(nph) < len_kij) begin
                    word[B_CEN_P] = 1'b0;
                    word[B_AP +: ADDR_W] =
                        ADDR_W'(int'(nph) * len_nij + int'(noo));
                end
                word[B_ACC] = (nph != '0);
            end
            default: ;
        endcase
        if (nstate != IDLE) word[B_MODE] = mode_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            inst   <= IDLE_WORD;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= nstate;
            inst   <= word;
            busy   <= (nstate != IDLE);
            done   <= (nstate == DONE);
            mode_q <= mode_n;
        end
    end

endmodule

// File: tb/tb_corelet_sequencer.sv
// Directed bench for corelet_sequencer with a small array:
// row=col=2, len_nij=4, len_kij=2, len_onij=2, wbase=1024.
module tb_corelet_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        ofifo_valid = 1'b1;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [34:0] tr [0:299];
    logic        bz [0:299];
    logic        dn [0:299];
    int          done_at;
    int          n_cyc;

    corelet_sequencer #(
        .row(2), .col(2), .len_nij(4), .len_onij(2),
        .len_kij(2), .wbase(1024)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(input bit m, input bit acc,
        input bit cp, input bit wp, input int ap, input bit cx,
        input bit wx, input int ax, input logic [6:0] lo);
        logic [10:0] a1;
        logic [10:0] a2;
        a1 = 11'(ap);
        a2 = 11'(ax);
        return {m, acc, cp, wp, a1, cx, wx, a2, lo};
    endfunction

    function automatic logic [34:0] idle_w(input logic [6:0] lo);
        return mk(0, 0, 1, 1, 0, 1, 1, 0, lo);
    endfunction

    function automatic logic [34:0] xrd(input int ax, input logic [6:0] lo);
        return mk(0, 0, 1, 1, 0, 0, 1, ax, lo);
    endfunction

    function automatic logic [34:0] pwr(input int ap, input logic [6:0] lo);
        return mk(0, 0, 0, 0, ap, 1, 1, 0, lo);
    endfunction

    function automatic logic [34:0] prd(input int ap, input bit acc);
        return mk(0, acc, 0, 1, ap, 1, 1, 0, 7'h00);
    endfunction

    // Cycle 0 is the first cycle after the start edge; valid low
    // during cycles st_lo..st_hi; a second start pulse at cycle again.
    task automatic run_pass(input bit m, input int st_lo, input int st_hi,
                            input int again);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mode    = 1'b0;
        done_at = -1;
        n_cyc   = 0;
        for (int c = 0; c < 300; c++) begin
            ofifo_valid = !(c >= st_lo && c <= st_hi);
            start = (c == again);
            @(negedge clk);
            tr[c] = inst;
            bz[c] = busy;
            dn[c] = done;
            n_cyc = c + 1;
            @(posedge clk);
            #1;
            if (done_at >= 0) break;
            if (dn[c]) done_at = c;
        end
        start = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    task automatic scan_writes(input string tag);
        int nw;
        int bad;
        nw  = 0;
        bad = 0;
        for (int c = 0; c < n_cyc; c++) begin
            if (!tr[c][32] && !tr[c][31]) begin
                if (int'(tr[c][30:20]) != nw) bad++;
                nw++;
            end
        end
        chk({tag, "_wr_cnt"}, nw, 8);
        chk({tag, "_wr_order"}, bad, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int nb;
        int nd;
        int nm;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_inst", inst, 35'h1_800C_0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        run_pass(0, -1, -1, -1);
        chk("p1_done_at", done_at, 52);
        chk("p1_wfill0", tr[0], xrd(1024, 7'h00));
        chk("p1_wfill1", tr[1], xrd(1025, 7'h04));
        chk("p1_wfill2", tr[2], idle_w(7'h04));
        chk("p1_wload", tr[3], idle_w(7'h09));
        chk("p1_wgap", tr[5], idle_w(7'h00));
        chk("p1_afill0", tr[9], xrd(0, 7'h00));
        chk("p1_afill3", tr[12], xrd(3, 7'h04));
        chk("p1_afill4", tr[13], idle_w(7'h04));
        chk("p1_aexec", tr[14], idle_w(7'h0A));
        chk("p1_drain0", tr[18], idle_w(7'h40));
        chk("p1_drain1", tr[19], pwr(0, 7'h40));
        chk("p1_drain4", tr[22], pwr(3, 7'h00));
        chk("p1_k1_wfill", tr[23], xrd(1026, 7'h00));
        chk("p1_k1_wfill1", tr[24], xrd(1027, 7'h04));
        chk("p1_k1_drain", tr[45], pwr(7, 7'h00));
        chk("p1_acc0", tr[46], prd(0, 0));
        chk("p1_acc1", tr[47], prd(4, 1));
        chk("p1_acc_gap0", tr[48], mk(0, 1, 1, 1, 0, 1, 1, 0, 7'h00));
        chk("p1_acc2", tr[49], prd(1, 0));
        chk("p1_acc3", tr[50], prd(5, 1));
        chk("p1_acc_gap1", tr[51], mk(0, 1, 1, 1, 0, 1, 1, 0, 7'h00));
        chk("p1_done_word", tr[52], idle_w(7'h00));
        chk("p1_after", tr[53], idle_w(7'h00));
        viol = 0;
        nb = 0;
        nd = 0;
        for (int c = 0; c < n_cyc; c++) begin
            if (tr[c][33] !== (c > 0 && !tr[c-1][32] && tr[c-1][31]))
                viol++;
            if (bz[c]) nb++;
            if (dn[c]) nd++;
        end
        chk("p1_acc_rule", viol, 0);
        chk("p1_busy_cycles", nb, 53);
        chk("p1_busy_after", bz[53], 0);
        chk("p1_done_pulses", nd, 1);
        scan_writes("p1");

        run_pass(0, 19, 21, -1);
        chk("st_done_at", done_at, 55);
        chk("st_c19", tr[19], pwr(0, 7'h40));
        chk("st_c20", tr[20], pwr(1, 7'h00));
        chk("st_c21", tr[21], idle_w(7'h00));
        chk("st_c22", tr[22], idle_w(7'h00));
        chk("st_c23", tr[23], idle_w(7'h40));
        chk("st_c24", tr[24], pwr(2, 7'h40));
        chk("st_c25", tr[25], pwr(3, 7'h00));
        chk("st_k1_wfill", tr[26], xrd(1026, 7'h00));
        scan_writes("st");

        run_pass(1, -1, -1, 10);
        chk("md_done_at", done_at, 52);
        nm = 0;
        for (int c = 0; c <= 52; c++) if (tr[c][34]) nm++;
        chk("md_bit34_cnt", nm, 53);
        chk("md_bit34_after", tr[53][34], 0);
        chk("md_done_word", tr[52], 35'h5_800C_0000);
        chk("md_wfill0", tr[0], xrd(1024, 7'h00) | (35'd1 << 34));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("md_idle_busy", busy, 0);

        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rm_pre_inst", inst, 35'h0_800C_000A | (35'd1 << 32));
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rm_inst", inst, 35'h1_800C_0000);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rm_stay_idle", busy, 0);
        @(posedge clk);
        #1;
        run_pass(0, -1, -1, -1);
        chk("rm_done_at", done_at, 52);
        chk("rm_wfill0", tr[0], xrd(1024, 7'h00));
        chk("rm_drain1", tr[19], pwr(0, 7'h40));
        scan_writes("rm");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
